window_fetcher: RTL

- Downstream neighbour of frame_buffer. Drives the frame buffer read port and sequences reads of a 3-row circular line store.
- Assembles one 3x3 pixel window per column of a selected centre row, sliding left to right, and presents each window with a valid/ready handshake to the convolution stage.
- Column borders use replicate (clamp) padding. Row neighbours wrap modulo P_ROWS.

---
 rtl/window_fetcher_if.sv | 28 ++
 rtl/window_fetcher.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/window_fetcher_if.sv
// Frame-buffer read port and window handshake bundle for window_fetcher.
// master = fetcher side, slave = frame buffer / convolution side.
interface window_fetcher_if #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
);
    logic [P_PIXEL_DEPTH-1:0]   I_FB_PIXEL;
    logic [$clog2(P_COLUMNS)-1:0] O_PIXEL_COL;
    logic [$clog2(P_ROWS)-1:0]  O_PIXEL_ROW;
    logic                       O_READ_ENABLE;
    logic [9*P_PIXEL_DEPTH-1:0] O_WINDOW;
    logic [$clog2(P_COLUMNS)-1:0] O_WINDOW_COL;
    logic                       O_WINDOW_VALID;
    logic                       I_WINDOW_READY;

    modport master (
        input  I_FB_PIXEL, I_WINDOW_READY,
        output O_PIXEL_COL, O_PIXEL_ROW, O_READ_ENABLE,
               O_WINDOW, O_WINDOW_COL, O_WINDOW_VALID
    );

    modport slave (
        output I_FB_PIXEL, I_WINDOW_READY,
        input  O_PIXEL_COL, O_PIXEL_ROW, O_READ_ENABLE,
               O_WINDOW, O_WINDOW_COL, O_WINDOW_VALID
    );
endinterface

// File: rtl/window_fetcher.sv
// Reads a 3-row circular line store column by column and presents one 3x3
// window per column of the centre row, with clamped column borders.
module window_fetcher #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                      I_CLK,
    input  logic                      I_RESET,
    input  logic                      I_ENABLE,
    input  logic                      I_START,
    input  logic [$clog2(P_ROWS)-1:0] I_CENTER_ROW,
    output logic                      O_BUSY,
    output logic                      O_ROW_DONE,
    window_fetcher_if.master          bus
);
    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam int PW = P_PIXEL_DEPTH;
    localparam logic [CW-1:0] LAST_COL = CW'(P_COLUMNS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(P_ROWS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, PRESENT, FETCH} state_t;

    state_t              state;
    logic [RW-1:0]       center;
    logic [CW-1:0]       col;
    logic [2:0]          rd_cnt;
    logic [2:0]          cap_cnt;
    logic [1:0]          vld_pipe;  // [0] read issued, [1] its data is on I_FB_PIXEL
    logic [2:0][PW-1:0]  win_l, win_m, win_r;
    logic [CW-1:0]       pix_col;
    logic [RW-1:0]       pix_row;
    logic                win_vld;
    logic                busy;
    logic                done;
    logic [1:0]          cap_slot;

    // slot 0 = top, 1 = mid, 2 = bottom; neighbours wrap around the line store
    function automatic logic [RW-1:0] row_of(input logic [RW-1:0] ctr, input logic [1:0] slot);
        case (slot)
            2'd0:    row_of = (ctr == '0) ? LAST_ROW : ctr - RW'(1);
            2'd2:    row_of = (ctr == LAST_ROW) ? '0 : ctr + RW'(1);
            default: row_of = ctr;
        endcase
    endfunction

    function automatic logic [1:0] slot_of(input logic [2:0] n);
        return (n >= 3'd3) ? 2'(n - 3'd3) : n[1:0];
    endfunction

    assign cap_slot = slot_of(cap_cnt);

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state    <= IDLE;
            center   <= '0;
            col      <= '0;
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            vld_pipe <= '0;
            win_l    <= '0;
            win_m    <= '0;
            win_r    <= '0;
            pix_col  <= '0;
            pix_row  <= '0;
            win_vld  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (I_ENABLE) begin
            vld_pipe <= {vld_pipe[0], 1'b0};
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_START) begin
                        state       <= PRIME;
                        center      <= I_CENTER_ROW;
                        col         <= '0;
                        busy        <= 1'b1;
                        vld_pipe[0] <= 1'b1;
                        pix_col     <= '0;
                        pix_row     <= row_of(I_CENTER_ROW, 2'd0);
                        rd_cnt      <= 3'd1;
                        cap_cnt     <= '0;
                    end
                end
                PRIME, FETCH: begin
                    if (rd_cnt < ((state == PRIME) ? 3'd6 : 3'd3)) begin
                        vld_pipe[0] <= 1'b1;
                        rd_cnt      <= rd_cnt + 3'd1;
                        pix_row     <= row_of(center, slot_of(rd_cnt));
                        if (state == PRIME)
                            pix_col <= (rd_cnt >= 3'd3) ? CW'(1) : '0;
                    end
                    if (vld_pipe[1]) begin
                        cap_cnt <= cap_cnt + 3'd1;
                        // column 0 is replicated into the left border
                        if (state == PRIME && cap_cnt < 3'd3) begin
                            win_l[cap_slot] <= bus.I_FB_PIXEL;
                            win_m[cap_slot] <= bus.I_FB_PIXEL;
                        end else begin
                            win_r[cap_slot] <= bus.I_FB_PIXEL;
                        end
                        if (cap_cnt == ((state == PRIME) ? 3'd5 : 3'd2)) begin
                            state   <= PRESENT;
                            win_vld <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.I_WINDOW_READY) begin
                        if (col == LAST_COL) begin
                            state   <= IDLE;
                            win_vld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            win_l <= win_m;
                            win_m <= win_r;
                            col   <= col + CW'(1);
                            // last column keeps the old right column: right border clamp
                            if (col + CW'(1) != LAST_COL) begin
                                state       <= FETCH;
                                win_vld     <= 1'b0;
                                vld_pipe[0] <= 1'b1;
                                pix_col     <= col + CW'(2);
                                pix_row     <= row_of(center, 2'd0);
                                rd_cnt      <= 3'd1;
                                cap_cnt     <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        assign bus.O_WINDOW[(3*r+0)*PW +: PW] = win_l[r];
        assign bus.O_WINDOW[(3*r+1)*PW +: PW] = win_m[r];
        assign bus.O_WINDOW[(3*r+2)*PW +: PW] = win_r[r];
    end

    assign bus.O_PIXEL_COL    = pix_col;
    assign bus.O_PIXEL_ROW    = pix_row;
    assign bus.O_READ_ENABLE  = vld_pipe[0] & I_ENABLE;
    assign bus.O_WINDOW_COL   = col;
    assign bus.O_WINDOW_VALID = win_vld;
    assign O_BUSY             = busy;
    assign O_ROW_DONE         = done;
endmodule
